// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: handshake and datapath-control bundle between the
// switch/LED front end (master) and the multiplier sequencer (slave).
interface mult_seq_ctrl_if #(
   parameter int CNT_W = 3
);
   logic             Run;
   logic             ClearA_LoadB;
   logic             M;
   logic             Clr_Ld;
   logic             Clear_XA;
   logic             Add_En;
   logic             Sub_En;
   logic             Shift_En;
   logic             Busy;
   logic             Done;
   logic [CNT_W-1:0] Count;
   modport master (
      output Run, ClearA_LoadB, M,
      input  Clr_Ld, Clear_XA, Add_En, Sub_En, Shift_En, Busy, Done, Count
   );
   modport slave (
      input  Run, ClearA_LoadB, M,
      output Clr_Ld, Clear_XA, Add_En, Sub_En, Shift_En, Busy, Done, Count
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for the add-shift signed multiplier; one add (or
// subtract on the sign bit) and one arithmetic shift per multiplier bit.
module mult_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input logic Clk,
   input logic Reset_n,
   mult_seq_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE:  state_nx = bus.Run ? CLR : IDLE;
         CLR: begin
            cnt_nx   = '0;
            state_nx = ADD;
         end
         ADD:   state_nx = SHIFT;
         SHIFT: begin
            state_nx = (cnt == LAST) ? HOLD : ADD;
            cnt_nx   = (cnt == LAST) ? cnt : cnt + CNT_W'(1);
         end
         // A held Run parks here so it cannot retrigger a second run.
         HOLD:  state_nx = bus.Run ? HOLD : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   assign bus.Clr_Ld   = (state == IDLE) & bus.ClearA_LoadB;
   assign bus.Clear_XA = (state == CLR);
   assign bus.Add_En   = (state == ADD) & bus.M;
   assign bus.Sub_En   = (state == ADD) & bus.M & (cnt == LAST);
   assign bus.Shift_En = (state == SHIFT);
   assign bus.Busy     = (state == CLR) | (state == ADD) | (state == SHIFT);
   assign bus.Done     = (state == HOLD);
   assign bus.Count    = cnt;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: table-driven and randomized checks of the multiplier
// sequencer against a cycle-index model of one multiplication.
module tb_mult_seq_ctrl;
   localparam int WIDTH = 8;
   localparam int CNT_W = 3;
   typedef logic [9:0] obs_t;
   typedef struct {
      logic [7:0] b;
      bit         pulse;
      int         hold;
      int         adds;
      int         subs;
   } vec_t;
   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic [7:0] b_sh = '0;
   logic [2:0] last_cnt = '0;
   int total = 0;
   int bad = 0;
   int n_add, n_sub, n_shift;
   vec_t tbl[6];
   mult_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();
   mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );
   always #5 Clk = ~Clk;
   assign bus.M = b_sh[0];

   function automatic obs_t obs();
      return {bus.Clr_Ld, bus.Clear_XA, bus.Add_En, bus.Sub_En, bus.Shift_En,
              bus.Busy, bus.Done, bus.Count};
   endfunction

   // Expected outputs k cycles after Run was sampled, for multiplier b.
   function automatic obs_t model(int k, logic [7:0] b, logic [2:0] prev);
      int i;
      if (k == 1) return {1'b0, 1'b1, 3'b000, 1'b1, 1'b0, prev};
      if (k >= 2 * WIDTH + 2) return {6'b000000, 1'b1, 3'(WIDTH - 1)};
      i = (k - 2) / 2;
      if (k % 2 == 0)
         return {1'b0, 1'b0, b[i], b[i] && i == WIDTH - 1, 1'b0, 1'b1, 1'b0, 3'(i)};
      return {4'b0000, 1'b1, 1'b1, 1'b0, 3'(i)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      logic s;
      s = bus.Shift_En;
      @(posedge Clk);
      #1;
      if (s) b_sh = b_sh >> 1;
   endtask

   task automatic run_mult(input logic [7:0] b, input bit pulse, input int hold, input bit rnd_clb);
      b_sh = b;
      n_add = 0;
      n_sub = 0;
      n_shift = 0;
      bus.ClearA_LoadB = rnd_clb;
      bus.Run = 1'b1;
      #1;
      chk("idle_clr_ld", {31'b0, bus.Clr_Ld}, {31'b0, rnd_clb});
      chk("idle_busy", {31'b0, bus.Busy}, 32'd0);
      step();
      if (pulse) bus.Run = 1'b0;
      for (int k = 1; k <= 2 * WIDTH + 1; k++) begin
         if (rnd_clb) bus.ClearA_LoadB = 1'($urandom_range(0, 1));
         #1;
         chk($sformatf("cyc%0d_b%02h", k, b), 32'(obs()), 32'(model(k, b, last_cnt)));
         n_add += int'(bus.Add_En);
         n_sub += int'(bus.Sub_En);
         n_shift += int'(bus.Shift_En);
         step();
      end
      bus.ClearA_LoadB = 1'b0;
      #1;
      last_cnt = 3'(WIDTH - 1);
      chk("done_cyc18", 32'(obs()), 32'(model(2 * WIDTH + 2, b, last_cnt)));
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_no_retrigger", 32'(obs()), 32'(model(2 * WIDTH + 2, b, last_cnt)));
      end
      bus.Run = 1'b0;
      step();
      chk("back_to_idle", 32'(obs()), {22'b0, 7'b0000000, last_cnt});
   endtask

   initial begin
      bus.Run = 1'b0;
      bus.ClearA_LoadB = 1'b0;
      tbl[0] = '{8'h03, 1'b0, 0, 2, 0};
      tbl[1] = '{8'h80, 1'b0, 2, 1, 1};
      tbl[2] = '{8'hFF, 1'b0, 10, 8, 1};
      tbl[3] = '{8'h00, 1'b0, 1, 0, 0};
      tbl[4] = '{8'h55, 1'b1, 0, 4, 0};
      tbl[5] = '{8'hAA, 1'b1, 0, 4, 1};
      #12;
      chk("reset_outputs", 32'(obs()), 32'd0);
      Reset_n = 1'b1;
      step();
      chk("idle_after_reset", 32'(obs()), 32'd0);
      bus.ClearA_LoadB = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("idle_load_held", 32'(obs()), {22'b0, 1'b1, 9'b0});
         step();
      end
      bus.ClearA_LoadB = 1'b0;
      for (int v = 0; v < 6; v++) begin
         run_mult(tbl[v].b, tbl[v].pulse, tbl[v].hold, 1'b0);
         chk($sformatf("adds_b%02h", tbl[v].b), 32'(n_add), 32'(tbl[v].adds));
         chk($sformatf("subs_b%02h", tbl[v].b), 32'(n_sub), 32'(tbl[v].subs));
         chk($sformatf("shifts_b%02h", tbl[v].b), 32'(n_shift), 32'd8);
      end
      for (int r = 0; r < 20; r++) begin
         logic [7:0] rb;
         rb = 8'($urandom);
         run_mult(rb, 1'($urandom_range(0, 1)), 0, 1'b1);
         chk("rnd_adds", 32'(n_add), 32'($countones(rb)));
         chk("rnd_subs", 32'(n_sub), {31'b0, rb[7]});
      end
      b_sh = 8'h12;
      bus.Run = 1'b1;
      step();
      bus.Run = 1'b0;
      repeat (10) step();
      chk("pre_reset_shift4", 32'(obs()), {22'b0, 7'b0000110, 3'd4});
      #2;
      Reset_n = 1'b0;
      #1;
      chk("async_busy", {31'b0, bus.Busy}, 32'd0);
      chk("async_count", 32'(bus.Count), 32'd0);
      chk("async_shift", {31'b0, bus.Shift_En}, 32'd0);
      bus.ClearA_LoadB = 1'b1;
      #1;
      chk("reset_clr_ld_follows", {31'b0, bus.Clr_Ld}, 32'd1);
      bus.ClearA_LoadB = 1'b0;
      #1;
      Reset_n = 1'b1;
      last_cnt = '0;
      step();
      chk("post_reset_idle", 32'(obs()), 32'd0);
      run_mult(8'h81, 1'b1, 0, 1'b0);
      chk("post_reset_adds", 32'(n_add), 32'd2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
